multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore FSM that sequences the shared RV32I datapath (PC, unified instruction/data memory port, register file, ALU) over multiple cycles, one instruction at a time.
- Drives all datapath enables and mux selects from the current state and the decoded opcode.
- Supports wait-states on the memory port through a ready handshake, with a timeout that halts the core on a hung bus.
- Keeps a retired-instruction counter for the test bench and debug.

Parameters:
TIMEOUT, 16, maximum cycles a memory state waits for mem_ready before halting with bus_err (range 1..255).
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-low reset (the CPU runs while rst=1).
opcode  input  7  inst[6:0] from the instruction register.
zero  input  1  ALU zero flag.
mem_ready  input  1  memory has completed the current read or write this cycle.
pc_en  output  1  PC load enable; equals pc_write | (pc_write_cond & zero).
ir_write  output  1  load instruction register and old_pc register.
mem_read  output  1  memory read request.
mem_write  output  1  memory write request.
i_or_d  output  1  memory address select: 0=PC, 1=ALUOut.
reg_write  output  1  register file write enable.
mem_to_reg  output  2  writeback select: 00=ALUOut, 01=MDR, 10=PC.
alu_src_a  output  2  ALU A select: 00=PC, 01=rs1 latch, 10=old_pc.
alu_src_b  output  2  ALU B select: 00=rs2 latch, 01=constant 4, 10=imm.
alu_op  output  2  to ALUCtrl: 00=add, 01=sub, 10=R-type funct, 11=I-type funct.
pc_source  output  1  PC input select: 0=ALU result, 1=ALUOut register.
halted  output  1  FSM is in HALT.
illegal  output  1  the halt was caused by an unknown opcode.
bus_err  output  1  the halt was caused by a memory timeout.
instret  output  CNT_W  count of retired instructions.

Behaviour:
- Reset (rst=0, asynchronous): state=FETCH, wait counter=0, instret=0, illegal=0, bus_err=0. All control outputs are forced to 0 while rst=0.
- Control outputs are combinational from the state. Any output not listed for a state is 0.
- FETCH: mem_read=1, i_or_d=0, a=00, b=01, alu_op=00.
  - ir_write=1, pc_write=1 and pc_source=0 only in the cycle where mem_ready=1; the FSM then moves to DECODE.
  - Otherwise the FSM stays in FETCH.
- DECODE: a=10, b=10, alu_op=00 (precomputes the branch/jal target into ALUOut). Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - anything else → HALT, with illegal set.
- EXEC_R: a=01, b=00, alu_op=10 → ALU_WB.
- EXEC_I: a=01, b=10, alu_op=11 → ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=00 → FETCH, retire.
- MEM_ADDR: a=01, b=10, alu_op=00 → MEM_RD for a load, MEM_WR for a store (opcode[5]=1 means store).
- MEM_RD: mem_read=1, i_or_d=1; on mem_ready → MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=01 → FETCH, retire.
- MEM_WR: mem_write=1, i_or_d=1; on mem_ready → FETCH, retire.
- BRANCH (beq only): a=01, b=00, alu_op=01, pc_write_cond=1, pc_source=1 → FETCH, retire.
- JAL: pc_write=1, pc_source=1, reg_write=1, mem_to_reg=10 (PC already holds old_pc+4) → FETCH, retire.
- Wait counter (FETCH, MEM_RD, MEM_WR):
  - Counts cycles with mem_ready=0 and clears when the state changes.
  - If it reaches TIMEOUT while mem_ready is still 0 → HALT, with bus_err set.
  - mem_ready=1 in the same cycle the count reaches TIMEOUT counts as completion, not timeout.
- HALT: all control outputs 0, halted=1. The FSM leaves HALT only through reset. illegal and bus_err are sticky until reset.
- Retire means instret increments by 1 on the edge that leaves the terminal state and wraps to 0 after 2^CNT_W-1. HALT does not retire.
- mem_ready is ignored in states that are not memory states.
- Cycle counts with zero wait-states:
  - R/I-type, load: 4/4/5 cycles (F, D, EX, WB; load adds MEM_RD).
  - store: 4 cycles.
  - branch, jal: 3 cycles.
- Reset asserted mid-instruction aborts it immediately: no retire, and all outputs are 0 within the same cycle.

Test Plan:
- Reset, then release with mem_ready tied to 1 and opcode=0110011 → state sequence FETCH, DECODE, EXEC_R, ALU_WB; reg_write=1 only in cycle 4; instret=1 after 4 cycles and 3 after 12.
- Load (0000011) with mem_ready low for 3 cycles in MEM_RD → mem_read and i_or_d held at 1 for 4 cycles; MEM_WB asserts mem_to_reg=01 and reg_write=1; total 8 cycles; instret+1.
- BEQ (1100011) with zero=1 → pc_en=1 in the BRANCH cycle. Repeat with zero=0 → pc_en=0 in that cycle. Both retire in 3 cycles.
- Opcode 0000000 → DECODE goes to HALT, illegal=1, halted=1, all enables 0 for 20 cycles; pulsing rst low clears the flags and returns to FETCH.
- TIMEOUT=16 with mem_ready held 0 in FETCH → HALT after exactly 16 cycles, bus_err=1, instret unchanged. A second run with mem_ready=1 at cycle 16 → DECODE, no bus_err.
- Preload instret at 2^32-1 (force), then one JAL → instret=0; reg_write=1 with mem_to_reg=10 and pc_en=1 in the JAL cycle.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM that sequences a shared multi-cycle RV32I datapath.
// It drives datapath enables and mux selects from the current state, waits on the
// memory ready handshake with a timeout, and counts retired instructions.
module multicycle_ctrl #(
   parameter int unsigned TIMEOUT = 16,  // 1..255 cycles of mem_ready=0 before bus_err
   parameter int unsigned CNT_W   = 32   // retired-instruction counter width
) (
   input  logic             clk,
   input  logic             rst,         // asynchronous, active low
   input  logic [6:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             ir_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic             i_or_d,
   output logic             reg_write,
   output logic [1:0]       mem_to_reg,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             pc_source,
   output logic             halted,
   output logic             illegal,
   output logic             bus_err,
   output logic [CNT_W-1:0] instret
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // Last wait count value; one more cycle without ready means the bus is hung.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR,
      MEM_RD, MEM_WB, MEM_WR, BRANCH, JAL, HALT
   } state_e;

   // Full set of state-decoded controls; pc_write/pc_write_cond fold into pc_en.
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       ir_write;
      logic       mem_read;
      logic       mem_write;
      logic       i_or_d;
      logic       reg_write;
      logic [1:0] mem_to_reg;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       pc_source;
      logic       halted;
   } ctl_t;

   state_e           state_q, state_d;
   logic [7:0]       wait_q, wait_d;
   logic             illegal_q, illegal_d;
   logic             bus_err_q, bus_err_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             retire;
   logic             mem_state;
   logic             timeout;
   ctl_t             ctl_c;
   ctl_t             ctl;

   assign mem_state = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
   // Ready in the last allowed cycle still counts as completion.
   assign timeout   = mem_state && !mem_ready && (wait_q == WAIT_LAST);

   // State, wait counter, sticky halt causes and retired-instruction counter.
   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= FETCH;
         wait_q    <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
         instret_q <= instret_d;
      end
   end

   // Next-state, per-state control decode, retire and wait-counter update.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d   = state_q;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      retire    = 1'b0;
      ctl_c     = '0;

      case (state_q)
         FETCH: begin
            ctl_c.mem_read  = 1'b1;
            ctl_c.alu_src_b = 2'b01;
            if (mem_ready) begin
               ctl_c.ir_write = 1'b1;
               ctl_c.pc_write = 1'b1;
               state_d        = DECODE;
            end else if (timeout) begin
               state_d   = HALT;
               bus_err_d = 1'b1;
            end
         end
         DECODE: begin
            ctl_c.alu_src_a = 2'b10;
            ctl_c.alu_src_b = 2'b10;
            case (opcode)
               OP_R:               state_d = EXEC_R;
               OP_I:               state_d = EXEC_I;
               OP_LOAD, OP_STORE:  state_d = MEM_ADDR;
               OP_BRANCH:          state_d = BRANCH;
               OP_JAL:             state_d = JAL;
               default: begin
                  state_d   = HALT;
                  illegal_d = 1'b1;
               end
            endcase
         end
         EXEC_R: begin
            ctl_c.alu_src_a = 2'b01;
            ctl_c.alu_src_b = 2'b00;
            ctl_c.alu_op    = 2'b10;
            state_d         = ALU_WB;
         end
         EXEC_I: begin
            ctl_c.alu_src_a = 2'b01;
            ctl_c.alu_src_b = 2'b10;
            ctl_c.alu_op    = 2'b11;
            state_d         = ALU_WB;
         end
         ALU_WB: begin
            ctl_c.reg_write = 1'b1;
            state_d         = FETCH;
            retire          = 1'b1;
         end
         MEM_ADDR: begin
            ctl_c.alu_src_a = 2'b01;
            ctl_c.alu_src_b = 2'b10;
            state_d         = opcode[5] ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            ctl_c.mem_read = 1'b1;
            ctl_c.i_or_d   = 1'b1;
            if (mem_ready) begin
               state_d = MEM_WB;
            end else if (timeout) begin
               state_d   = HALT;
               bus_err_d = 1'b1;
            end
         end
         MEM_WB: begin
            ctl_c.reg_write  = 1'b1;
            ctl_c.mem_to_reg = 2'b01;
            state_d          = FETCH;
            retire           = 1'b1;
         end
         MEM_WR: begin
            ctl_c.mem_write = 1'b1;
            ctl_c.i_or_d    = 1'b1;
            if (mem_ready) begin
               state_d = FETCH;
               retire  = 1'b1;
            end else if (timeout) begin
               state_d   = HALT;
               bus_err_d = 1'b1;
            end
         end
         BRANCH: begin
            ctl_c.alu_src_a     = 2'b01;
            ctl_c.alu_src_b     = 2'b00;
            ctl_c.alu_op        = 2'b01;
            ctl_c.pc_write_cond = 1'b1;
            ctl_c.pc_source     = 1'b1;
            state_d             = FETCH;
            retire              = 1'b1;
         end
         JAL: begin
            // PC already holds old_pc+4 from FETCH, so it is the link value.
            ctl_c.pc_write   = 1'b1;
            ctl_c.pc_source  = 1'b1;
            ctl_c.reg_write  = 1'b1;
            ctl_c.mem_to_reg = 2'b10;
            state_d          = FETCH;
            retire           = 1'b1;
         end
         HALT: begin
            ctl_c.halted = 1'b1;
         end
         default: begin
            state_d = HALT;
         end
      endcase

      // The wait count restarts on every state change.
      if (state_d != state_q) begin
         wait_d = '0;
      end else if (mem_state && !mem_ready) begin
         wait_d = wait_q + 8'd1;
      end else begin
         wait_d = wait_q;
      end

      instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
   end

   // All controls drop to 0 combinationally while reset is held.
   assign ctl        = rst ? ctl_c : '0;
   assign pc_en      = ctl.pc_write | (ctl.pc_write_cond & zero);
   assign ir_write   = ctl.ir_write;
   assign mem_read   = ctl.mem_read;
   assign mem_write  = ctl.mem_write;
   assign i_or_d     = ctl.i_or_d;
   assign reg_write  = ctl.reg_write;
   assign mem_to_reg = ctl.mem_to_reg;
   assign alu_src_a  = ctl.alu_src_a;
   assign alu_src_b  = ctl.alu_src_b;
   assign alu_op     = ctl.alu_op;
   assign pc_source  = ctl.pc_source;
   assign halted     = ctl.halted;
   assign illegal    = illegal_q;
   assign bus_err    = bus_err_q;
   assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
module tb_multicycle_ctrl;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BAD    = 7'b0000000;

   // Expected control word, bit order:
   // pc_en ir_write mem_read mem_write i_or_d reg_write mem_to_reg[2] a[2] b[2] alu_op[2]
   // pc_source halted illegal bus_err
   localparam logic [17:0] C_ZERO   = 18'b0_0_0_0_0_0_00_00_00_00_0_0_0_0;
   localparam logic [17:0] C_FWAIT  = 18'b0_0_1_0_0_0_00_00_01_00_0_0_0_0;
   localparam logic [17:0] C_FDONE  = 18'b1_1_1_0_0_0_00_00_01_00_0_0_0_0;
   localparam logic [17:0] C_DEC    = 18'b0_0_0_0_0_0_00_10_10_00_0_0_0_0;
   localparam logic [17:0] C_EXR    = 18'b0_0_0_0_0_0_00_01_00_10_0_0_0_0;
   localparam logic [17:0] C_EXI    = 18'b0_0_0_0_0_0_00_01_10_11_0_0_0_0;
   localparam logic [17:0] C_ALUWB  = 18'b0_0_0_0_0_1_00_00_00_00_0_0_0_0;
   localparam logic [17:0] C_MADDR  = 18'b0_0_0_0_0_0_00_01_10_00_0_0_0_0;
   localparam logic [17:0] C_MRD    = 18'b0_0_1_0_1_0_00_00_00_00_0_0_0_0;
   localparam logic [17:0] C_MWB    = 18'b0_0_0_0_0_1_01_00_00_00_0_0_0_0;
   localparam logic [17:0] C_MWR    = 18'b0_0_0_1_1_0_00_00_00_00_0_0_0_0;
   localparam logic [17:0] C_BR_T   = 18'b1_0_0_0_0_0_00_01_00_01_1_0_0_0;
   localparam logic [17:0] C_BR_NT  = 18'b0_0_0_0_0_0_00_01_00_01_1_0_0_0;
   localparam logic [17:0] C_JAL    = 18'b1_0_0_0_0_1_10_00_00_00_1_0_0_0;
   localparam logic [17:0] C_H_ILL  = 18'b0_0_0_0_0_0_00_00_00_00_0_1_1_0;
   localparam logic [17:0] C_H_BUS  = 18'b0_0_0_0_0_0_00_00_00_00_0_1_0_1;

   logic        clk;
   logic        rst;
   logic [6:0]  opcode;
   logic        zero;
   logic        mem_ready;
   logic        pc_en, ir_write, mem_read, mem_write, i_or_d, reg_write;
   logic [1:0]  mem_to_reg, alu_src_a, alu_src_b, alu_op;
   logic        pc_source, halted, illegal, bus_err;
   logic [31:0] instret;
   logic [17:0] ctl_w;

   int checks = 0;
   int errors = 0;

   multicycle_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .pc_en      (pc_en),
      .ir_write   (ir_write),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .i_or_d     (i_or_d),
      .reg_write  (reg_write),
      .mem_to_reg (mem_to_reg),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .pc_source  (pc_source),
      .halted     (halted),
      .illegal    (illegal),
      .bus_err    (bus_err),
      .instret    (instret)
   );

   assign ctl_w = {pc_en, ir_write, mem_read, mem_write, i_or_d, reg_write, mem_to_reg,
                   alu_src_a, alu_src_b, alu_op, pc_source, halted, illegal, bus_err};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Apply inputs for one cycle, check the control word, then advance past the edge.
   task automatic cyc(input logic [6:0] op, input logic rdy, input logic z,
                      input logic [17:0] exp, input string tag);
      opcode    = op;
      mem_ready = rdy;
      zero      = z;
      #1;
      chk(tag, {14'd0, ctl_w}, {14'd0, exp});
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset(input string tag);
      rst = 1'b0;
      #1;
      chk({tag, "_rst_ctl"}, {14'd0, ctl_w}, 32'd0);
      chk({tag, "_rst_cnt"}, instret, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      rst       = 1'b0;
      opcode    = OP_R;
      zero      = 1'b0;
      mem_ready = 1'b1;
      #2;
      chk("reset_ctl", {14'd0, ctl_w}, 32'd0);
      chk("reset_instret", instret, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Three R-type instructions with zero wait-states.
      for (int n = 1; n <= 3; n++) begin
         cyc(OP_R, 1'b1, 1'b0, C_FDONE, "r_fetch");
         cyc(OP_R, 1'b1, 1'b0, C_DEC,   "r_decode");
         cyc(OP_R, 1'b1, 1'b0, C_EXR,   "r_exec");
         cyc(OP_R, 1'b1, 1'b0, C_ALUWB, "r_wb");
         if (n == 1) chk("instret_after_4", instret, 32'd1);
      end
      chk("instret_after_12", instret, 32'd3);

      // Load with three wait-states in MEM_RD: 8 cycles total.
      cyc(OP_LOAD, 1'b1, 1'b0, C_FDONE, "ld_fetch");
      cyc(OP_LOAD, 1'b1, 1'b0, C_DEC,   "ld_decode");
      cyc(OP_LOAD, 1'b1, 1'b0, C_MADDR, "ld_addr");
      for (int i = 0; i < 3; i++) cyc(OP_LOAD, 1'b0, 1'b0, C_MRD, "ld_rd_wait");
      cyc(OP_LOAD, 1'b1, 1'b0, C_MRD,   "ld_rd_done");
      chk("ld_no_retire_yet", instret, 32'd3);
      cyc(OP_LOAD, 1'b1, 1'b0, C_MWB,   "ld_wb");
      chk("ld_instret", instret, 32'd4);

      // Store, 4 cycles.
      cyc(OP_STORE, 1'b1, 1'b0, C_FDONE, "st_fetch");
      cyc(OP_STORE, 1'b1, 1'b0, C_DEC,   "st_decode");
      cyc(OP_STORE, 1'b1, 1'b0, C_MADDR, "st_addr");
      cyc(OP_STORE, 1'b1, 1'b0, C_MWR,   "st_wr");
      chk("st_instret", instret, 32'd5);

      // I-type with mem_ready low outside memory states (must be ignored).
      cyc(OP_I, 1'b1, 1'b0, C_FDONE, "i_fetch");
      cyc(OP_I, 1'b0, 1'b0, C_DEC,   "i_decode");
      cyc(OP_I, 1'b0, 1'b0, C_EXI,   "i_exec");
      cyc(OP_I, 1'b0, 1'b0, C_ALUWB, "i_wb");
      chk("i_instret", instret, 32'd6);

      // BEQ taken, then not taken; 3 cycles each.
      cyc(OP_BRANCH, 1'b1, 1'b1, C_FDONE, "beq_t_fetch");
      cyc(OP_BRANCH, 1'b1, 1'b1, C_DEC,   "beq_t_decode");
      cyc(OP_BRANCH, 1'b1, 1'b1, C_BR_T,  "beq_taken");
      cyc(OP_BRANCH, 1'b1, 1'b0, C_FDONE, "beq_n_fetch");
      cyc(OP_BRANCH, 1'b1, 1'b0, C_DEC,   "beq_n_decode");
      cyc(OP_BRANCH, 1'b1, 1'b0, C_BR_NT, "beq_not_taken");
      chk("beq_instret", instret, 32'd8);

      // Fetch stalls 15 cycles, ready arrives in cycle 16: completion, not timeout.
      for (int i = 0; i < 15; i++) cyc(OP_R, 1'b0, 1'b0, C_FWAIT, "late_fetch_wait");
      cyc(OP_R, 1'b1, 1'b0, C_FDONE, "late_fetch_done");
      cyc(OP_R, 1'b1, 1'b0, C_DEC,   "late_decode");
      chk("late_no_bus_err", {31'd0, bus_err}, 32'd0);
      cyc(OP_R, 1'b1, 1'b0, C_EXR,   "late_exec");
      cyc(OP_R, 1'b1, 1'b0, C_ALUWB, "late_wb");
      chk("late_instret", instret, 32'd9);

      // Illegal opcode halts; 20 cycles of HALT regardless of inputs.
      cyc(OP_BAD, 1'b1, 1'b0, C_FDONE, "ill_fetch");
      cyc(OP_BAD, 1'b1, 1'b0, C_DEC,   "ill_decode");
      for (int i = 0; i < 20; i++) cyc(OP_R, i[0], 1'b1, C_H_ILL, "ill_halt");
      chk("ill_instret", instret, 32'd9);
      pulse_reset("ill");
      cyc(OP_JAL, 1'b1, 1'b0, C_FDONE, "post_ill_fetch");

      // One JAL so the counter is non-zero, then a fetch timeout.
      cyc(OP_JAL, 1'b1, 1'b0, C_DEC, "jal1_decode");
      cyc(OP_JAL, 1'b1, 1'b0, C_JAL, "jal1_exec");
      chk("jal1_instret", instret, 32'd1);
      for (int i = 0; i < 16; i++) cyc(OP_R, 1'b0, 1'b0, C_FWAIT, "to_fetch_wait");
      for (int i = 0; i < 3; i++)  cyc(OP_R, 1'b1, 1'b0, C_H_BUS, "to_halt");
      chk("to_instret", instret, 32'd1);
      pulse_reset("to");

      // Counter wrap: preload all ones during DECODE, JAL retires to 0.
      cyc(OP_JAL, 1'b1, 1'b0, C_FDONE, "wrap_fetch");
      force dut.instret_q = 32'hFFFF_FFFF;
      #1;
      release dut.instret_q;
      chk("wrap_preload", instret, 32'hFFFF_FFFF);
      cyc(OP_JAL, 1'b1, 1'b0, C_DEC, "wrap_decode");
      chk("wrap_hold", instret, 32'hFFFF_FFFF);
      cyc(OP_JAL, 1'b1, 1'b0, C_JAL, "wrap_jal");
      chk("wrap_instret", instret, 32'd0);

      // Reset mid-instruction in ALU_WB aborts with no retire.
      cyc(OP_R, 1'b1, 1'b0, C_FDONE, "abort_fetch");
      cyc(OP_R, 1'b1, 1'b0, C_DEC,   "abort_decode");
      cyc(OP_R, 1'b1, 1'b0, C_EXR,   "abort_exec");
      pulse_reset("abort");
      cyc(OP_R, 1'b1, 1'b0, C_FDONE, "abort_refetch");
      chk("abort_instret", instret, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
